fp_addsub_pipe: RTL and testbench

Parametrised, pipelined modular adder/subtractor over GF(P) for the SQISign field-arithmetic datapath. It accepts one operand pair per cycle under a valid/ready handshake and selects add or subtract per transaction. It returns the fully reduced result in [0, P) with a fixed latency, a pass-through tag and an operand-range error flag. It is the general replacement for the fixed 255-bit, add-only, always-flowing adder, and feeds the same consumers (multiplier front-end, curve-arithmetic sequencers).

---
 rtl/fp_addsub_pipe.sv | 98 +++++++++
 tb/tb_fp_addsub_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage modular adder/subtractor over GF(P) with a valid/ready handshake.
// A single global advance enable moves every stage at once, so order is always kept.
module fp_addsub_pipe #(
   parameter int unsigned  W     = 255,
   parameter logic [W-1:0] P     = 255'd2261564242916331941866620800950935700259179388000792266395655937654553313279,
   parameter int unsigned  TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_d,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam logic [W:0] PX = {1'b0, P};

   // One conditional correction; the low W bits of r -/+ P equal r[W-1:0] -/+ P mod 2^W.
   function automatic logic [W-1:0] reduce(input logic op, input logic [W:0] r);
      if (!op && (r >= PX)) return r[W-1:0] - P;
      else if (op && r[W])  return r[W-1:0] + P;
      else                  return r[W-1:0];
   endfunction

   logic             adv;

   logic             vld_p1_q, op_p1_q, err_p1_q, err_p1_d;
   logic [W-1:0]     a_p1_q, b_p1_q;
   logic [TAG_W-1:0] tag_p1_q;

   logic             vld_p2_q, op_p2_q, err_p2_q;
   logic [W:0]       raw_p2_q, raw_p2_d;
   logic [TAG_W-1:0] tag_p2_q;

   logic             vld_p3_q, err_p3_q;
   logic [W-1:0]     d_p3_q, d_p3_d;
   logic [TAG_W-1:0] tag_p3_q;

   assign adv      = !vld_p3_q | out_ready;
   assign in_ready = adv;

   assign err_p1_d = (in_a >= P) | (in_b >= P);
   assign raw_p2_d = op_p1_q ? ({1'b0, a_p1_q} - {1'b0, b_p1_q})
                             : ({1'b0, a_p1_q} + {1'b0, b_p1_q});
   assign d_p3_d   = reduce(op_p2_q, raw_p2_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         op_p1_q  <= 1'b0;
         err_p1_q <= 1'b0;
         a_p1_q   <= '0;
         b_p1_q   <= '0;
         tag_p1_q <= '0;
         vld_p2_q <= 1'b0;
         op_p2_q  <= 1'b0;
         err_p2_q <= 1'b0;
         raw_p2_q <= '0;
         tag_p2_q <= '0;
         vld_p3_q <= 1'b0;
         err_p3_q <= 1'b0;
         d_p3_q   <= '0;
         tag_p3_q <= '0;
      end else if (adv) begin
         // S1: capture operands and range-check them
         vld_p1_q <= in_valid & in_ready;
         op_p1_q  <= in_op;
         err_p1_q <= err_p1_d;
         a_p1_q   <= in_a;
         b_p1_q   <= in_b;
         tag_p1_q <= in_tag;
         // S2: raw W+1-bit sum or two's-complement difference
         vld_p2_q <= vld_p1_q;
         op_p2_q  <= op_p1_q;
         err_p2_q <= err_p1_q;
         raw_p2_q <= raw_p2_d;
         tag_p2_q <= tag_p1_q;
         // S3: reduced result, drives the outputs directly
         vld_p3_q <= vld_p2_q;
         err_p3_q <= err_p2_q;
         d_p3_q   <= d_p3_d;
         tag_p3_q <= tag_p2_q;
      end
   end

   assign out_valid = vld_p3_q;
   assign out_d     = d_p3_q;
   assign out_tag   = tag_p3_q;
   assign out_err   = err_p3_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: a W=8/P=251 instance for directed and backpressure work,
// and a default-parameter instance for reset and long random streaming.
module tb_fp_addsub_pipe;

   localparam int unsigned  WB = 255;
   localparam logic [WB-1:0] PB = 255'd2261564242916331941866620800950935700259179388000792266395655937654553313279;
   localparam int unsigned  NSTREAM = 1000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // small instance
   logic       s_in_valid, s_in_ready, s_in_op, s_out_valid, s_out_ready, s_out_err;
   logic [7:0] s_in_a, s_in_b, s_out_d;
   logic [3:0] s_in_tag, s_out_tag;

   // default instance
   logic          b_in_valid, b_in_ready, b_in_op, b_out_valid, b_out_ready, b_out_err;
   logic [WB-1:0] b_in_a, b_in_b, b_out_d;
   logic [3:0]    b_in_tag, b_out_tag;

   fp_addsub_pipe #(.W(8), .P(8'd251), .TAG_W(4)) dut_s (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
      .in_a(s_in_a), .in_b(s_in_b), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_d(s_out_d), .out_tag(s_out_tag), .out_err(s_out_err));

   fp_addsub_pipe dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
      .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_d(b_out_d), .out_tag(b_out_tag), .out_err(b_out_err));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference models ----------------
   function automatic logic [7:0] ref_s(input logic op, input logic [7:0] a, input logic [7:0] b);
      int r;
      if (!op) r = (int'(a) + int'(b)) % 251;
      else     r = (int'(a) + 251 - int'(b)) % 251;
      return 8'(r);
   endfunction

   function automatic logic [WB-1:0] ref_b(input logic op, input logic [WB-1:0] a, input logic [WB-1:0] b);
      logic [256:0] t;
      t = {2'b00, a};
      if (!op) t = t + {2'b00, b};
      else     t = t + {2'b00, PB} - {2'b00, b};
      t = t % {2'b00, PB};
      return t[WB-1:0];
   endfunction

   function automatic logic [WB-1:0] rand_big();
      logic [255:0] x;
      logic [255:0] y;
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
      y = x % {1'b0, PB};
      case ($urandom_range(0, 15))
         0:       return '0;
         1:       return PB - 1;
         default: return y[WB-1:0];
      endcase
   endfunction

   // ---------------- scoreboards (sampled on the falling edge) ----------------
   typedef struct { logic [7:0] d; logic [3:0] tag; logic err; } sexp_t;
   typedef struct { logic [WB-1:0] d; logic [3:0] tag; } bexp_t;

   sexp_t s_q[$];
   bexp_t b_q[$];
   bit    s_sb_en = 1'b0;
   int    s_sent = 0, s_got = 0, b_got = 0;
   logic  s_hold_pend = 1'b0;
   logic [7:0] s_hold_d;
   logic [3:0] s_hold_tag;

   always @(negedge clk) begin
      if (s_sb_en) begin
         sexp_t e;
         check("s_in_ready_rule", {255'd0, s_in_ready}, {255'd0, (!s_out_valid | s_out_ready)});
         if (s_hold_pend) begin
            check("s_hold_valid", {255'd0, s_out_valid}, 256'd1);
            check("s_hold_d", {248'd0, s_out_d}, {248'd0, s_hold_d});
            check("s_hold_tag", {252'd0, s_out_tag}, {252'd0, s_hold_tag});
         end
         s_hold_pend = s_out_valid && !s_out_ready;
         s_hold_d    = s_out_d;
         s_hold_tag  = s_out_tag;
         if (!rst && s_in_valid && s_in_ready) begin
            e.d = ref_s(s_in_op, s_in_a, s_in_b);
            e.tag = s_in_tag;
            e.err = 1'b0;
            s_q.push_back(e);
            s_sent++;
         end
         if (s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
               check("s_unexpected_out", 256'd1, 256'd0);
            end else begin
               e = s_q.pop_front();
               s_got++;
               check("s_bp_d", {248'd0, s_out_d}, {248'd0, e.d});
               check("s_bp_tag", {252'd0, s_out_tag}, {252'd0, e.tag});
               check("s_bp_err", {255'd0, s_out_err}, {255'd0, e.err});
            end
         end
      end
   end

   always @(negedge clk) begin
      bexp_t e;
      if (!rst && b_in_valid && b_in_ready) begin
         e.d = ref_b(b_in_op, b_in_a, b_in_b);
         e.tag = b_in_tag;
         b_q.push_back(e);
      end
      if (b_out_valid && b_out_ready) begin
         if (b_q.size() == 0) begin
            check("b_unexpected_out", 256'd1, 256'd0);
         end else begin
            e = b_q.pop_front();
            b_got++;
            check("b_stream_d", {1'b0, b_out_d}, {1'b0, e.d});
            check("b_stream_tag", {252'd0, b_out_tag}, {252'd0, e.tag});
            check("b_stream_err", {255'd0, b_out_err}, 256'd0);
         end
      end
   end

   // ---------------- directed vectors for the small instance ----------------
   typedef struct {
      logic       op;
      logic [7:0] a, b;
      logic [3:0] tag;
      logic [7:0] exp_d;
      logic       exp_err;
      logic       chk_d;
   } vec_t;

   vec_t vecs[11];

   task automatic run_vec(input vec_t v);
      int lat;
      @(posedge clk); #1;
      s_in_valid = 1'b1; s_in_op = v.op; s_in_a = v.a; s_in_b = v.b; s_in_tag = v.tag;
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (s_out_valid || lat > 10) break;
         lat++;
      end
      check("s_vec_latency", 256'(lat), 256'd3);
      if (v.chk_d) check("s_vec_d", {248'd0, s_out_d}, {248'd0, v.exp_d});
      check("s_vec_tag", {252'd0, s_out_tag}, {252'd0, v.tag});
      check("s_vec_err", {255'd0, s_out_err}, {255'd0, v.exp_err});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall;
      vecs[0]  = '{1'b0, 8'd200, 8'd100, 4'd5,  8'd49,  1'b0, 1'b1};
      vecs[1]  = '{1'b0, 8'd250, 8'd0,   4'd6,  8'd250, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 8'd3,   8'd10,  4'd7,  8'd244, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 8'd10,  8'd3,   4'd8,  8'd7,   1'b0, 1'b1};
      vecs[4]  = '{1'b1, 8'd0,   8'd0,   4'd9,  8'd0,   1'b0, 1'b1};
      vecs[5]  = '{1'b1, 8'd250, 8'd250, 4'd10, 8'd0,   1'b0, 1'b1};
      vecs[6]  = '{1'b0, 8'd250, 8'd250, 4'd11, 8'd249, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 8'd0,   8'd250, 4'd12, 8'd1,   1'b0, 1'b1};
      vecs[8]  = '{1'b0, 8'd255, 8'd1,   4'd13, 8'd0,   1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'd1,   8'd1,   4'd14, 8'd2,   1'b0, 1'b1};
      vecs[10] = '{1'b1, 8'd5,   8'd252, 4'd15, 8'd0,   1'b1, 1'b0};

      rst = 1'b1;
      s_in_valid = 1'b1; s_in_op = 1'b0; s_in_a = 8'd7; s_in_b = 8'd9; s_in_tag = 4'd3; s_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_op = 1'b0; b_in_a = 255'd7; b_in_b = 255'd9; b_in_tag = 4'd3; b_out_ready = 1'b1;

      // reset held two cycles with inputs offered
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_b_out_valid", {255'd0, b_out_valid}, 256'd0);
         check("rst_b_out_d", {1'b0, b_out_d}, 256'd0);
         check("rst_s_out_valid", {255'd0, s_out_valid}, 256'd0);
         check("rst_s_out_d", {248'd0, s_out_d}, 256'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0; s_in_valid = 1'b0; b_in_valid = 1'b0;
      @(negedge clk);
      check("rst_b_in_ready", {255'd0, b_in_ready}, 256'd1);
      check("rst_s_in_ready", {255'd0, s_in_ready}, 256'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_b_out_valid", {255'd0, b_out_valid}, 256'd0);
         check("post_rst_s_out_valid", {255'd0, s_out_valid}, 256'd0);
      end

      // directed table on the small instance
      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // reset while two transactions are in flight
      @(posedge clk); #1;
      s_in_valid = 1'b1; s_in_op = 1'b0; s_in_a = 8'd1; s_in_b = 8'd2; s_in_tag = 4'd1;
      @(posedge clk); #1;
      s_in_tag = 4'd2;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; s_in_valid = 1'b0;
      check("midrst_out_d", {248'd0, s_out_d}, 256'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_out_valid", {255'd0, s_out_valid}, 256'd0);
      end

      // random traffic with backpressure on the small instance
      s_sb_en = 1'b1;
      stall = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (stall > 0) begin
            s_out_ready = 1'b0; stall--;
         end else if ($urandom_range(0, 9) == 0) begin
            stall = $urandom_range(5, 8); s_out_ready = 1'b0;
         end else begin
            s_out_ready = ($urandom_range(0, 3) != 0);
         end
         s_in_valid = ($urandom_range(0, 2) != 0);
         s_in_op    = 1'($urandom_range(0, 1));
         s_in_a     = 8'($urandom_range(0, 250));
         s_in_b     = 8'($urandom_range(0, 250));
         s_in_tag   = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_out_ready = 1'b1;
      for (int i = 0; i < 20 && (s_q.size() != 0 || s_out_valid); i++) @(posedge clk);
      #1;
      check("s_bp_drained", 256'(s_q.size()), 256'd0);
      check("s_bp_count", 256'(s_got), 256'(s_sent));
      s_sb_en = 1'b0;

      // long random stream on the default instance
      for (int i = 0; i < NSTREAM; i++) begin
         @(posedge clk); #1;
         b_in_valid = 1'b1; b_out_ready = 1'b1;
         b_in_op  = 1'($urandom_range(0, 1));
         b_in_a   = rand_big();
         b_in_b   = rand_big();
         b_in_tag = 4'(i);
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      @(posedge clk); #1;
      check("b_stream_count", 256'(b_got), 256'(NSTREAM));
      check("b_stream_drained", 256'(b_q.size()), 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
